muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multi-cycle multiply/divide unit for MULT/MULTU/DIV/DIVU, sitting beside the exec stage. It consumes operands forwarded into exec and produces the 64-bit hi/lo pair that the writeback stage commits to the hilo register. Its `busy` output feeds the hazard unit, which stalls the exec stage and everything upstream of it. A `flush` input aborts in-flight work when an exception flushes exec.

## Interface
- `MULT_LATENCY`, default 2: cycles from the accepted start to `done` for multiplies; legal range 1..4.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a new operation; sampled only when state is IDLE or DONE.
- `op`  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  32  rs operand; dividend for DIV/DIVU.
- `b`  in  32  rt operand; divisor for DIV/DIVU.
- `flush`  in  1  abort any in-flight operation.
- `busy`  out  1  operation in progress; the hazard unit stalls exec while this is high.
- `done`  out  1  one-cycle pulse; `hi`/`lo` are valid from this cycle.
- `hi`  out  32  product[63:32] for multiplies; remainder for divides.
- `lo`  out  32  product[31:0] for multiplies; quotient for divides.

## Operation
- States: IDLE, MUL, DIV, SIGN, DONE.
- `a`, `b` and `op` are registered when a start is accepted. Later changes on these inputs are ignored.
- IDLE/DONE with `start`:
  - Multiply with MULT_LATENCY=1: go to DONE.
  - Multiply with MULT_LATENCY>1: go to MUL.
  - Divide: go to DIV with the step counter set to 31.
- IDLE/DONE without `start`: go to IDLE.
- MUL:
  - Holds for MULT_LATENCY-1 cycles, then goes to DONE.
  - Product is 64-bit signed for MULT and unsigned for MULTU.
  - The product may be computed combinationally and registered, or pipelined, provided the latency is exact.
- DIV:
  - Restoring division, one quotient bit per cycle, on 32-bit magnitudes.
  - Magnitudes: absolute values for DIV, raw values for DIVU.
  - Remainder register is 33 bits wide internally.
  - At counter 0, go to SIGN.
- SIGN (one cycle):
  - DIV: negate the quotient iff `a[31]` differs from `b[31]`; negate the remainder iff `a[31]`=1.
  - DIVU: pass through.
  - Write `hi`/`lo`, then go to DONE.
- DONE: `done`=1 for exactly one cycle.
- `hi`/`lo` change only on the cycle `done` rises. They hold their value until the next completed operation; a flush never changes them.
- Divide by zero (`b`=0), for both DIV and DIVU:
  - `lo`=0xFFFFFFFF, `hi`=`a`.
  - Normal latency; no exception raised.
- DIV 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0. No trap.
- `busy`=1 in MUL, DIV and SIGN; 0 in IDLE and DONE.
- `start` while `busy`=1 is ignored. The hazard unit guarantees it is not issued.
- `flush`:
  - Takes priority over everything except `reset`.
  - Next state is IDLE, with `busy`=0 and `done`=0 from the next cycle.
  - `start` in the same cycle as `flush` is dropped.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter 0.
- Cycle 0 is the cycle in which `start` is sampled high.
- Multiply: `busy`=1 in cycles 1..MULT_LATENCY-1; `done`=1 in cycle MULT_LATENCY. Default: `done` in cycle 2.
- Divide: DIV state in cycles 1..32, SIGN in cycle 33, `done` in cycle 34. `busy`=1 in cycles 1..33.
- Back-to-back: `start` in the DONE cycle is accepted, giving zero idle cycles between operations.
- `reset` mid-operation: all outputs return to reset values on the next edge; `hi`/`lo` are cleared.
- `flush` in cycle k during DIV: `busy`=0 in cycle k+1, and no `done` is generated for the aborted operation.

## Test plan
- MULT `a`=0xFFFFFFFD (-3), `b`=5 -> `done` in cycle 2; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. MULTU with the same operands -> `hi`=0x00000004, `lo`=0xFFFFFFF1.
- DIVU 100/7 -> `busy` high in cycles 1..33, `done` in cycle 34 only; `lo`=14, `hi`=2.
- DIV -7/2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV 7/-2 -> `lo`=0xFFFFFFFD, `hi`=1. DIV 0x80000000/0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- DIV 0x12345678/0 -> `done` in cycle 34; `lo`=0xFFFFFFFF, `hi`=0x12345678.
- Flush check, in sequence:
  - Complete MULTU 2*3 (`lo`=6).
  - Start DIVU 100/7 and assert `flush` in cycle 10 -> `busy`=0 from cycle 11, no `done`, `lo` stays 6.
  - Start DIVU 9/4 in the next cycle -> `lo`=2, `hi`=1 after 34 cycles.
- Start handling:
  - Toggle `start` with different operands during a DIV -> ignored; the result matches the original operands.
  - `start` in the DONE cycle -> the new operation proceeds with no gap.
  - `start` and `flush` together -> nothing starts.

Source files
------------

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// muldiv_unit : multi-cycle MULT/MULTU/DIV/DIVU unit producing the hi/lo pair
// Revision    : 1.0
// ============================================================================
module muldiv_unit #(
   parameter int MULT_LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MUL  = 3'd1,
      S_DIV  = 3'd2,
      S_SIGN = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [4:0] c_mul_cnt = (MULT_LATENCY > 1) ? 5'(MULT_LATENCY - 2) : 5'd0;

   state_t      r_state;
   state_t      w_next;
   logic        w_accept;
   logic        w_load;

   logic [31:0] r_a;
   logic [31:0] r_b;
   logic        r_signed;
   logic [4:0]  r_cnt;
   logic [31:0] r_quo;
   logic [31:0] r_dvs;
   logic [32:0] r_rem;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_accept = 1'b1;
               if (op[1])
                  w_next = S_DIV;
               else if (MULT_LATENCY == 1)
                  w_next = S_DONE;
               else
                  w_next = S_MUL;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_MUL:   if (r_cnt == 5'd0) w_next = S_DONE;
         S_DIV:   if (r_cnt == 5'd0) w_next = S_SIGN;
         S_SIGN:  w_next = S_DONE;
         default: w_next = S_IDLE;
      endcase
      if (flush) begin
         w_next   = S_IDLE;
         w_accept = 1'b0;
      end
   end

   // Every entry into DONE (including DONE->DONE at latency 1) publishes a result.
   assign w_load = (w_next == S_DONE);
   assign busy   = (r_state == S_MUL) || (r_state == S_DIV) || (r_state == S_SIGN);
   assign done   = (r_state == S_DONE);

   // ------------------------------------------------------------------
   // Multiplier: single 64x64 array; operands come straight from the
   // inputs when the result is due on the accepting edge (latency 1).
   // ------------------------------------------------------------------
   logic        w_from_in;
   logic [31:0] w_pa;
   logic [31:0] w_pb;
   logic        w_psgn;
   logic [63:0] w_ext_a;
   logic [63:0] w_ext_b;
   logic [63:0] w_prod;

   assign w_from_in = (r_state != S_MUL);
   assign w_pa      = w_from_in ? a : r_a;
   assign w_pb      = w_from_in ? b : r_b;
   assign w_psgn    = w_from_in ? ~op[0] : r_signed;
   assign w_ext_a   = {{32{w_psgn & w_pa[31]}}, w_pa};
   assign w_ext_b   = {{32{w_psgn & w_pb[31]}}, w_pb};
   assign w_prod    = w_ext_a * w_ext_b;

   // ------------------------------------------------------------------
   // Restoring divider on magnitudes
   // ------------------------------------------------------------------
   logic [31:0] w_mag_a;
   logic [31:0] w_mag_b;
   logic [33:0] w_trial;
   logic [32:0] w_shift;
   logic        w_q_neg;
   logic        w_r_neg;
   logic [31:0] w_div_hi;
   logic [31:0] w_div_lo;
   logic [31:0] w_res_hi;
   logic [31:0] w_res_lo;

   assign w_mag_a = (~op[0] & a[31]) ? (32'd0 - a) : a;
   assign w_mag_b = (~op[0] & b[31]) ? (32'd0 - b) : b;
   assign w_trial = {r_rem, r_quo[31]} - {2'b00, r_dvs};
   assign w_shift = {r_rem[31:0], r_quo[31]};

   assign w_q_neg = r_signed & (r_a[31] ^ r_b[31]);
   assign w_r_neg = r_signed & r_a[31];

   // Zero divisor is forced explicitly so the signed path does not negate it.
   assign w_div_lo = (r_b == 32'd0) ? 32'hFFFF_FFFF
                   : (w_q_neg ? (32'd0 - r_quo) : r_quo);
   assign w_div_hi = (r_b == 32'd0) ? r_a
                   : (w_r_neg ? (32'd0 - r_rem[31:0]) : r_rem[31:0]);

   assign w_res_hi = (r_state == S_SIGN) ? w_div_hi : w_prod[63:32];
   assign w_res_lo = (r_state == S_SIGN) ? w_div_lo : w_prod[31:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_a      <= 32'd0;
         r_b      <= 32'd0;
         r_signed <= 1'b0;
         r_cnt    <= 5'd0;
         r_quo    <= 32'd0;
         r_dvs    <= 32'd0;
         r_rem    <= 33'd0;
         hi       <= 32'd0;
         lo       <= 32'd0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_signed <= ~op[0];
            r_quo    <= w_mag_a;
            r_dvs    <= w_mag_b;
            r_rem    <= 33'd0;
            r_cnt    <= op[1] ? 5'd31 : c_mul_cnt;
         end else if (r_state == S_DIV) begin
            r_cnt <= r_cnt - 5'd1;
            if (!w_trial[33]) begin
               r_rem <= w_trial[32:0];
               r_quo <= {r_quo[30:0], 1'b1};
            end else begin
               r_rem <= w_shift;
               r_quo <= {r_quo[30:0], 1'b0};
            end
         end else if ((r_state == S_MUL) && (r_cnt != 5'd0)) begin
            r_cnt <= r_cnt - 5'd1;
         end
         if (w_load) begin
            hi <= w_res_hi;
            lo <= w_res_lo;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// tb_muldiv_unit : directed self-checking bench for muldiv_unit
// Revision       : 1.0
// ============================================================================
module tb_muldiv_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_total = 0;
   int n_pass  = 0;

   muldiv_unit #(.MULT_LATENCY(2)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .flush (flush),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp)
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      else
         n_pass++;
   endtask

   // Called at a negedge; leaves the bench at the negedge of cycle 1.
   task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(negedge clk);
      start = 1'b0;
      op    = ~o;
      a     = ~x;
      b     = ~y;
   endtask

   // Starts at the negedge of cycle cyc0; returns at the negedge where done is seen.
   task automatic wait_done(input int cyc0, input int lat, input string tag);
      int cyc;
      int nbusy;
      cyc   = cyc0;
      nbusy = 0;
      while (done !== 1'b1 && cyc < 60) begin
         if (busy === 1'b1) nbusy++;
         @(negedge clk);
         cyc++;
      end
      check({tag, " latency"}, cyc, lat);
      check({tag, " busy cycles"}, nbusy, lat - cyc0);
      check({tag, " busy at done"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int lat, input logic [31:0] ehi, input logic [31:0] elo,
                        input string tag);
      launch(o, x, y);
      wait_done(1, lat, tag);
      check({tag, " hi"}, hi, ehi);
      check({tag, " lo"}, lo, elo);
   endtask

   initial begin
      int nd;
      reset = 1'b1;
      start = 1'b0;
      flush = 1'b0;
      op    = 2'd0;
      a     = 32'd0;
      b     = 32'd0;
      repeat (3) @(negedge clk);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset hi", hi, 32'd0);
      check("reset lo", lo, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Multiplies, the second issued in the DONE cycle of the first
      do_op(2'b00, 32'hFFFF_FFFD, 32'd5, 2, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult -3*5");
      do_op(2'b01, 32'hFFFF_FFFD, 32'd5, 2, 32'h0000_0004, 32'hFFFF_FFF1, "multu b2b");
      do_op(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 2, 32'hC000_0000, 32'h8000_0000, "mult big");
      do_op(2'b01, 32'h7FFF_FFFF, 32'h8000_0000, 2, 32'h3FFF_FFFF, 32'h8000_0000, "multu big");
      @(negedge clk);

      do_op(2'b11, 32'd100, 32'd7, 34, 32'd2, 32'd14, "divu 100/7");
      @(negedge clk);
      check("done one cycle", {31'd0, done}, 32'd0);
      check("idle busy", {31'd0, busy}, 32'd0);

      do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div -7/2");
      do_op(2'b10, 32'd7, 32'hFFFF_FFFE, 34, 32'd1, 32'hFFFF_FFFD, "div 7/-2");
      do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'd0, 32'h8000_0000, "div min/-1");
      do_op(2'b10, 32'h1234_5678, 32'd0, 34, 32'h1234_5678, 32'hFFFF_FFFF, "div by zero");
      do_op(2'b10, 32'hFFFF_FFF0, 32'd0, 34, 32'hFFFF_FFF0, 32'hFFFF_FFFF, "div neg by zero");
      do_op(2'b11, 32'hFFFF_FFF0, 32'd0, 34, 32'hFFFF_FFF0, 32'hFFFF_FFFF, "divu by zero");

      // Flush mid-divide, then a fresh divide in the following cycle
      do_op(2'b01, 32'd2, 32'd3, 2, 32'd0, 32'd6, "multu 2*3");
      @(negedge clk);
      launch(2'b11, 32'd100, 32'd7);
      repeat (9) @(negedge clk);
      check("busy before flush", {31'd0, busy}, 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush busy", {31'd0, busy}, 32'd0);
      check("flush done", {31'd0, done}, 32'd0);
      check("flush lo kept", lo, 32'd6);
      do_op(2'b11, 32'd9, 32'd4, 34, 32'd1, 32'd2, "divu 9/4 after flush");

      // start together with flush is dropped
      @(negedge clk);
      start = 1'b1;
      flush = 1'b1;
      op    = 2'b11;
      a     = 32'd50;
      b     = 32'd5;
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      check("start+flush busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("start+flush busy later", {31'd0, busy}, 32'd0);
      check("start+flush done", {31'd0, done}, 32'd0);
      check("start+flush lo", lo, 32'd2);

      // start toggled with other operands while a divide is running
      launch(2'b11, 32'd100, 32'd7);
      for (int i = 0; i < 5; i++) begin
         start = (i % 2 == 0);
         op    = 2'b00;
         a     = 32'd3;
         b     = 32'd3;
         @(negedge clk);
      end
      start = 1'b0;
      wait_done(6, 34, "divu toggled");
      check("divu toggled hi", hi, 32'd2);
      check("divu toggled lo", lo, 32'd14);

      // reset in the middle of a divide
      @(negedge clk);
      launch(2'b10, 32'd100, 32'd3);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mid reset busy", {31'd0, busy}, 32'd0);
      check("mid reset hi", hi, 32'd0);
      check("mid reset lo", lo, 32'd0);
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) nd++;
         @(negedge clk);
      end
      check("mid reset no done", nd, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
